// File: rtl/comp_pkg.sv
// Shared types and constants for the X^2 compute-unit sequencing controller.
package comp_pkg;

  localparam int unsigned N_MAX = 1024;
  localparam int unsigned CNT_W = 11;
  localparam logic [CNT_W-1:0] N_MAX_V = CNT_W'(N_MAX);

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_WDOG  = 2'd1;
  localparam logic [1:0] ERR_BAD_N = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CU_RST,
    S_LOAD_X,
    S_WAIT_XACK,
    S_WAIT_Y,
    S_DONE,
    S_ERR
  } state_t;

  function automatic logic n_is_legal(input logic [CNT_W-1:0] n);
    return (n != '0) && (n <= N_MAX_V);
  endfunction

endpackage

// File: rtl/comp_watchdog.sv
// Loadable down-counter: expired flags the last enabled cycle of a full TIMEOUT window.
module comp_watchdog #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);
  localparam int unsigned W = $clog2(TIMEOUT + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= W'(TIMEOUT);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  // A load in the same cycle means progress was made, so it masks expiry.
  assign o_expired = i_en && !i_load && (r_cnt <= W'(1));

endmodule

// File: rtl/comp_ctrl.sv
// Sequences X words into the compute unit and collects Y words into a one-entry buffer,
// with watchdog, abort and illegal-count reporting.
module comp_ctrl
  import comp_pkg::*;
#(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] i_cfg_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_x_wr_valid,
  input  logic [31:0]      i_x_wr_data,
  output logic             o_x_wr_ready,
  output logic             o_y_rd_valid,
  output logic [31:0]      o_y_rd_data,
  input  logic             i_y_rd_ready,
  output logic             o_cu_reset,
  output logic [CNT_W-1:0] o_cu_n,
  output logic [31:0]      o_cu_x_elem,
  output logic             o_cu_new_x,
  input  logic             i_cu_x_stored,
  input  logic             i_cu_new_y,
  input  logic [31:0]      i_cu_y_elem,
  output logic             o_cu_y_stored,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [1:0]       o_err_code,
  output logic [CNT_W-1:0] o_x_count,
  output logic [CNT_W-1:0] o_y_count
);

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_n, r_x_count, r_y_count;
  logic [31:0]      r_x_elem, r_y_data;
  logic             r_new_x, r_y_valid, r_y_stored, r_cu_reset;
  logic             r_busy, r_done, r_error, r_rst_cnt, r_abort_path;
  logic [1:0]       r_err_code;

  logic w_idle_like, w_n_legal, w_x_push, w_x_ack, w_y_cap, w_y_rel, w_y_pop;
  logic w_wd_en, w_wd_load, w_wd_expired;

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
  assign w_n_legal   = n_is_legal(i_cfg_n);
  assign w_x_push    = (r_state == S_LOAD_X) && i_x_wr_valid && !i_cu_x_stored;
  assign w_x_ack     = (r_state == S_WAIT_XACK) && i_cu_x_stored;
  // r_y_stored stays high until the unit drops NEW_Y, so one word is never captured twice.
  assign w_y_cap     = (r_state == S_WAIT_Y) && i_cu_new_y && !r_y_valid && !r_y_stored;
  assign w_y_rel     = r_y_stored && !i_cu_new_y;
  assign w_y_pop     = r_y_valid && i_y_rd_ready;

  // Only unit-side waits are timed; a full buffer means the CPU is the one stalling.
  assign w_wd_en   = (r_state == S_WAIT_XACK) || ((r_state == S_WAIT_Y) && !r_y_valid);
  assign w_wd_load = !w_wd_en || w_x_ack || w_y_cap || w_y_rel;

  comp_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (i_abort),
    .i_load    (w_wd_load),
    .i_en      (w_wd_en),
    .o_expired (w_wd_expired)
  );

  always_comb begin
    w_state_next = r_state;
    if (i_abort) begin
      w_state_next = S_CU_RST;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: if (i_start) w_state_next = w_n_legal ? S_CU_RST : S_ERR;
        S_CU_RST:    if (r_rst_cnt) w_state_next = r_abort_path ? S_IDLE : S_LOAD_X;
        S_LOAD_X:    if (w_x_push) w_state_next = S_WAIT_XACK;
        S_WAIT_XACK: begin
          if (i_cu_x_stored)
            w_state_next = ((r_x_count + CNT_W'(1)) == r_n) ? S_WAIT_Y : S_LOAD_X;
          else if (w_wd_expired)
            w_state_next = S_ERR;
        end
        S_WAIT_Y: begin
          if ((r_y_count == r_n) && !r_y_valid) w_state_next = S_DONE;
          else if (w_wd_expired) w_state_next = S_ERR;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_n          <= '0;
      r_x_count    <= '0;
      r_y_count    <= '0;
      r_x_elem     <= '0;
      r_y_data     <= '0;
      r_new_x      <= 1'b0;
      r_y_valid    <= 1'b0;
      r_y_stored   <= 1'b0;
      r_cu_reset   <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_rst_cnt    <= 1'b0;
      r_abort_path <= 1'b0;
      r_err_code   <= ERR_NONE;
    end else begin
      r_state    <= w_state_next;
      r_cu_reset <= (w_state_next == S_CU_RST);
      r_busy     <= !((w_state_next == S_IDLE) || (w_state_next == S_DONE) || (w_state_next == S_ERR));
      r_done     <= (w_state_next == S_DONE);
      r_error    <= (w_state_next == S_ERR);
      r_rst_cnt  <= (r_state == S_CU_RST) && !i_abort && !r_rst_cnt;
      if (i_abort) begin
        r_abort_path <= 1'b1;
        r_new_x      <= 1'b0;
        r_y_stored   <= 1'b0;
        r_y_valid    <= 1'b0;
        r_x_count    <= '0;
        r_y_count    <= '0;
      end else begin
        if (w_idle_like && i_start) begin
          if (w_n_legal) begin
            r_n          <= i_cfg_n;
            r_x_count    <= '0;
            r_y_count    <= '0;
            r_err_code   <= ERR_NONE;
            r_abort_path <= 1'b0;
          end else begin
            r_err_code <= ERR_BAD_N;
          end
        end
        if (w_x_push) begin
          r_x_elem <= i_x_wr_data;
          r_new_x  <= 1'b1;
        end
        if (w_x_ack) begin
          r_new_x   <= 1'b0;
          r_x_count <= r_x_count + CNT_W'(1);
        end
        if (w_wd_expired) begin
          r_err_code <= ERR_WDOG;
          r_new_x    <= 1'b0;
        end
        if (w_y_pop) r_y_valid <= 1'b0;
        if (w_y_rel) r_y_stored <= 1'b0;
        if (w_y_cap) begin
          r_y_data   <= i_cu_y_elem;
          r_y_valid  <= 1'b1;
          r_y_stored <= 1'b1;
          r_y_count  <= r_y_count + CNT_W'(1);
        end
      end
    end
  end

  assign o_x_wr_ready  = (r_state == S_LOAD_X) && !i_cu_x_stored;
  assign o_y_rd_valid  = r_y_valid;
  assign o_y_rd_data   = r_y_data;
  assign o_cu_reset    = r_cu_reset;
  assign o_cu_n        = r_n;
  assign o_cu_x_elem   = r_x_elem;
  assign o_cu_new_x    = r_new_x;
  assign o_cu_y_stored = r_y_stored;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_error       = r_error;
  assign o_err_code    = r_err_code;
  assign o_x_count     = r_x_count;
  assign o_y_count     = r_y_count;

endmodule

// File: doc/comp_ctrl.md
# comp_ctrl

Sequencing controller between the processor-side register interface and the X²-compute unit. Takes an element count and start command, feeds X words one at a time to the unit over its NEW_X / X_STORED handshake, and collects Y words over the NEW_Y / Y_STORED handshake into a one-entry read buffer. Also provides progress counters, a watchdog, abort and error reporting. Sits directly under the memory-mapped register slave; the compute unit is its only downstream client.

## Interface
- N_MAX, 1024: largest legal element count.
- TIMEOUT, 65535: cycles without progress before a watchdog error.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- cfg_n  in  11  element count; sampled only on an accepted start.
- start  in  1  one-cycle pulse; honoured in IDLE, DONE and ERR.
- abort  in  1  one-cycle pulse; honoured in any state.
- x_wr_valid / x_wr_data / x_wr_ready  in/in/out  1/32/1  CPU X push, valid/ready.
- y_rd_valid / y_rd_data / y_rd_ready  out/out/in  1/32/1  CPU Y pop, valid/ready.
- cu_reset  out  1  reset to the compute unit.
- cu_n  out  11  count to the unit; equals the latched N.
- cu_x_elem  out  32  X word to the unit.
- cu_new_x  out  1  asserted while cu_x_elem is valid and not yet stored.
- cu_x_stored  in  1  unit has stored the current X.
- cu_new_y / cu_y_elem  in  1/32  unit presents a Y word.
- cu_y_stored  out  1  controller has captured the current Y.
- busy, done, error  out  1 each  status.
- err_code  out  2  0 none, 1 watchdog, 2 illegal N.
- x_count, y_count  out  11 each  words pushed to the unit / captured from it.

## Operation
- States: IDLE, CU_RST, LOAD_X, WAIT_XACK, WAIT_Y, DONE, ERR.
- IDLE/DONE/ERR + start:
  - If cfg_n is 0 or greater than N_MAX: go to ERR with err_code=2.
  - Otherwise: latch N, clear both counters, error and err_code, and go to CU_RST.
- CU_RST: cu_reset=1 for exactly 2 cycles, then go to LOAD_X.
- LOAD_X: x_wr_ready = !cu_x_stored.
  - On an accepted push: latch the data into cu_x_elem, set cu_new_x=1, and go to WAIT_XACK.
- WAIT_XACK: on cu_x_stored=1, clear cu_new_x and increment x_count.
  - If x_count reaches N, go to WAIT_Y; otherwise go back to LOAD_X.
- WAIT_Y: when cu_new_y=1 and the buffer is empty:
  - capture cu_y_elem into y_rd_data;
  - set y_rd_valid=1 and increment y_count;
  - set cu_y_stored=1 and hold it until cu_new_y falls.
  - When y_count==N and the buffer is empty, go to DONE.
- y_rd_valid clears on the cycle y_rd_ready is seen. The buffer is never overwritten while full, because cu_new_y is ignored while full.
- busy = state not in {IDLE, DONE, ERR}. done=1 only in DONE. error=1 only in ERR.
- Watchdog:
  - A counter resets on every handshake event and on state entry, and counts only in WAIT_XACK and WAIT_Y.
  - When it reaches TIMEOUT: go to ERR with err_code=1.
  - CPU-side stalls in LOAD_X, or y_rd_ready low, never time out.
- abort in any state: go to CU_RST, then IDLE (not LOAD_X). Clear cu_new_x, cu_y_stored, y_rd_valid and the counters.
- Counters are 11 bits wide; N ≤ 1024, so they never wrap.

## Timing
- Reset values:
  - state IDLE; all counters 0;
  - cu_reset=1 while reset is high, 0 on the first cycle after;
  - all other outputs 0, including x_wr_ready, y_rd_data and err_code.
- All outputs are registered except x_wr_ready.
- start accepted at cycle t: cu_reset high at t+1 and t+2; LOAD_X with x_wr_ready=1 at t+3.
- Push accepted at cycle t: cu_new_x=1 from t+1. cu_x_stored seen at cycle s: cu_new_x=0 at s+1.
- cu_new_y seen at cycle s with the buffer empty: y_rd_valid=1 and cu_y_stored=1 at s+1.
- Simultaneous events:
  - abort and start in the same cycle: abort wins.
  - reset beats everything.
  - y_rd_ready and a new capture in the same cycle: the capture waits one cycle.
- start while busy is ignored.

## Structure
- Shared package `comp_pkg`:
  - state enum;
  - err_code constants;
  - N_MAX.
- One sub-module, `comp_watchdog`: a loadable down-counter with clear, enable and an expired flag.
- Y buffer and handshake logic stay inline.

## Test plan
- N=4, X=1,2,3,4, y_rd_ready tied 1 -> Y=4,16,36,64; done=1; x_count=y_count=4.
- Same run with y_rd_ready low for 20 cycles per word -> same Y sequence, no drop or duplicate, no watchdog error.
- cfg_n=0, and separately cfg_n=1025 -> ERR next cycle; err_code=2; cu_reset never pulsed.
- Stub unit that never raises cu_x_stored, TIMEOUT=16 -> error=1 and err_code=1 exactly 16 cycles after WAIT_XACK entry.
- abort after 2 of 4 X pushes -> cu_reset high 2 cycles, then IDLE, counters 0. A new start with N=2, X=5,6 -> Y=100,144.
- reset asserted in WAIT_Y -> all outputs at reset values the next cycle.
